// File: rtl/syn_run_ctrl_pkg.sv
// rtl/syn_run_ctrl_pkg.sv - shared state codes and constants for the run controller
package syn_run_ctrl_pkg;

  localparam int RUN_STATE_W = 2;

  // State codes are visible on the state output, so their encodings are fixed.
  typedef enum logic [RUN_STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_HALTED = 2'd3
  } run_state_e;

  // A step request of zero still grants one enabled cycle.
  function automatic logic [31:0] step_load(input logic [31:0] num);
    return (num == 32'd0) ? 32'd1 : num;
  endfunction

endpackage

// File: rtl/syn_sat_counter.sv
// rtl/syn_sat_counter.sv - saturating event counter with synchronous clear
module syn_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count up on inc, stick at all-ones, clear has priority over inc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/syn_run_ctrl.sv
// rtl/syn_run_ctrl.sv - run/step/stop controller gating the CPU pipeline enable
module syn_run_ctrl
  import syn_run_ctrl_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int STEP_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_run,
  input  logic              cmd_step,
  input  logic              cmd_stop,
  input  logic              cmd_clr,
  input  logic [STEP_W-1:0] step_num,
  input  logic              halt,
  input  logic              is_jump,
  input  logic              is_branch,
  input  logic              branched,
  output logic              cpu_en,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  cyc_cnt,
  output logic [CNT_W-1:0]  jmp_cnt,
  output logic [CNT_W-1:0]  br_cnt,
  output logic [CNT_W-1:0]  tkn_cnt
);

  run_state_e        state_q, state_d;
  logic [STEP_W-1:0] remaining_q, remaining_d;
  logic [STEP_W-1:0] step_init;

  // Zero-length step requests are widened to a single cycle.
  assign step_init = (step_num == '0) ? STEP_W'(1) : step_num;

  // Halt drops the enable in the same cycle it is raised.
  assign cpu_en = ((state_q == ST_RUN) || (state_q == ST_STEP)) && !halt;
  assign state  = state_q;

  // State and step-budget registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
    end
  end

  // Command decode: clr beats everything, then halt, then stop > step > run.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    if (cmd_clr) begin
      state_d     = ST_IDLE;
      remaining_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cmd_stop) begin
            state_d = ST_IDLE;
          end else if (cmd_step) begin
            state_d     = ST_STEP;
            remaining_d = step_init;
          end else if (cmd_run) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (halt) begin
            state_d = ST_HALTED;
          end else if (cmd_stop) begin
            state_d = ST_IDLE;
          end
        end
        ST_STEP: begin
          if (halt) begin
            state_d = ST_HALTED;
          end else if (cmd_stop) begin
            state_d     = ST_IDLE;
            remaining_d = '0;
          end else begin
            remaining_d = remaining_q - STEP_W'(1);
            if (remaining_q == STEP_W'(1)) begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_HALTED: begin
          state_d = ST_HALTED;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  syn_sat_counter #(.W(CNT_W)) u_cyc_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cmd_clr),
    .inc   (cpu_en),
    .cnt   (cyc_cnt)
  );

  syn_sat_counter #(.W(CNT_W)) u_jmp_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cmd_clr),
    .inc   (cpu_en && is_jump),
    .cnt   (jmp_cnt)
  );

  syn_sat_counter #(.W(CNT_W)) u_br_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cmd_clr),
    .inc   (cpu_en && is_branch),
    .cnt   (br_cnt)
  );

  syn_sat_counter #(.W(CNT_W)) u_tkn_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cmd_clr),
    .inc   (cpu_en && is_branch && branched),
    .cnt   (tkn_cnt)
  );

endmodule

// File: tb/tb_syn_run_ctrl.sv
// tb/tb_syn_run_ctrl.sv - self-checking bench for syn_run_ctrl
module tb_syn_run_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_run, cmd_step, cmd_stop, cmd_clr;
  logic [15:0] step_num;
  logic        halt, is_jump, is_branch, branched;

  logic        cpu_en, cpu_en4;
  logic [1:0]  state, state4;
  logic [31:0] cyc_cnt, jmp_cnt, br_cnt, tkn_cnt;
  logic [3:0]  cyc_cnt4, jmp_cnt4, br_cnt4, tkn_cnt4;

  int n_cmp = 0;
  int n_err = 0;
  int en_seen = 0;

  // reference model: mode 0 idle, 1 run, 2 step, 3 halted
  int     m_mode;
  int     m_rem;
  longint m_cyc, m_jmp, m_br, m_tkn;

  always #5 clk = ~clk;

  syn_run_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_run(cmd_run), .cmd_step(cmd_step), .cmd_stop(cmd_stop), .cmd_clr(cmd_clr),
    .step_num(step_num), .halt(halt),
    .is_jump(is_jump), .is_branch(is_branch), .branched(branched),
    .cpu_en(cpu_en), .state(state),
    .cyc_cnt(cyc_cnt), .jmp_cnt(jmp_cnt), .br_cnt(br_cnt), .tkn_cnt(tkn_cnt)
  );

  syn_run_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .cmd_run(cmd_run), .cmd_step(cmd_step), .cmd_stop(cmd_stop), .cmd_clr(cmd_clr),
    .step_num(step_num), .halt(halt),
    .is_jump(is_jump), .is_branch(is_branch), .branched(branched),
    .cpu_en(cpu_en4), .state(state4),
    .cyc_cnt(cyc_cnt4), .jmp_cnt(jmp_cnt4), .br_cnt(br_cnt4), .tkn_cnt(tkn_cnt4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint sat15(input longint v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_rem = 0;
    m_cyc = 0; m_jmp = 0; m_br = 0; m_tkn = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":state"},  64'(state),    64'(m_mode));
    chk({tag, ":state4"}, 64'(state4),   64'(m_mode));
    chk({tag, ":cyc"},    64'(cyc_cnt),  64'(m_cyc));
    chk({tag, ":jmp"},    64'(jmp_cnt),  64'(m_jmp));
    chk({tag, ":br"},     64'(br_cnt),   64'(m_br));
    chk({tag, ":tkn"},    64'(tkn_cnt),  64'(m_tkn));
    chk({tag, ":cyc4"},   64'(cyc_cnt4), 64'(sat15(m_cyc)));
    chk({tag, ":jmp4"},   64'(jmp_cnt4), 64'(sat15(m_jmp)));
    chk({tag, ":br4"},    64'(br_cnt4),  64'(sat15(m_br)));
    chk({tag, ":tkn4"},   64'(tkn_cnt4), 64'(sat15(m_tkn)));
  endtask

  // One clock: check the combinational enable, clock, advance the model, check registers.
  task automatic tick(input string tag);
    logic en_exp;
    #1;
    en_exp = ((m_mode == 1) || (m_mode == 2)) && !halt;
    chk({tag, ":cpu_en"},  64'(cpu_en),  64'(en_exp));
    chk({tag, ":cpu_en4"}, 64'(cpu_en4), 64'(en_exp));
    if (cpu_en === 1'b1) en_seen++;
    @(posedge clk);
    if (cmd_clr) begin
      model_reset();
    end else begin
      if (en_exp) begin
        m_cyc++;
        if (is_jump) m_jmp++;
        if (is_branch) m_br++;
        if (is_branch && branched) m_tkn++;
      end
      case (m_mode)
        0: if (!cmd_stop) begin
             if (cmd_step) begin
               m_mode = 2;
               m_rem = (step_num == 0) ? 1 : int'(step_num);
             end else if (cmd_run) begin
               m_mode = 1;
             end
           end
        1: if (halt) m_mode = 3; else if (cmd_stop) m_mode = 0;
        2: if (halt) m_mode = 3;
           else if (cmd_stop) begin m_mode = 0; m_rem = 0; end
           else begin m_rem--; if (m_rem == 0) m_mode = 0; end
        default: ;
      endcase
    end
    #1;
    check_all(tag);
    cmd_run = 0; cmd_step = 0; cmd_stop = 0; cmd_clr = 0;
  endtask

  task automatic idle_inputs();
    cmd_run = 0; cmd_step = 0; cmd_stop = 0; cmd_clr = 0;
    step_num = '0; halt = 0; is_jump = 0; is_branch = 0; branched = 0;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    rst_n = 0;
    #12;
    chk("reset:cpu_en", 64'(cpu_en), 64'd0);
    check_all("reset");
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // step of 5
    step_num = 16'd5; cmd_step = 1; tick("step5_cmd");
    en_seen = 0;
    for (int i = 0; i < 8; i++) tick("step5_run");
    chk("step5_en_cycles", 64'(en_seen), 64'd5);
    chk("step5_state",     64'(state),   64'd0);
    chk("step5_cyc",       64'(cyc_cnt), 64'd5);

    // step of zero
    cmd_clr = 1; tick("step0_clr");
    step_num = 16'd0; cmd_step = 1; tick("step0_cmd");
    en_seen = 0;
    for (int i = 0; i < 4; i++) tick("step0_run");
    chk("step0_en_cycles", 64'(en_seen), 64'd1);
    chk("step0_cyc",       64'(cyc_cnt), 64'd1);

    // halt at enabled cycle 7
    cmd_clr = 1; tick("halt_clr");
    cmd_run = 1; tick("halt_run");
    for (int i = 0; i < 6; i++) tick("halt_pre");
    halt = 1; #1;
    chk("halt_en_same_cycle", 64'(cpu_en), 64'd0);
    tick("halt_edge");
    halt = 0;
    chk("halt_state", 64'(state),   64'd3);
    chk("halt_cyc",   64'(cyc_cnt), 64'd6);
    cmd_run = 1; tick("halt_run_ignored");
    chk("halt_still", 64'(state), 64'd3);
    cmd_clr = 1; tick("halt_clear");
    chk("halt_clr_state", 64'(state),   64'd0);
    chk("halt_clr_cyc",   64'(cyc_cnt), 64'd0);

    // priority
    cmd_run = 1; tick("prio_run");
    tick("prio_running");
    cmd_run = 1; cmd_stop = 1; tick("prio_run_stop");
    chk("prio_stop_wins", 64'(state), 64'd0);
    cmd_run = 1; tick("prio_run2");
    tick("prio_running2");
    cmd_clr = 1; cmd_step = 1; step_num = 16'd3; tick("prio_clr_step");
    chk("prio_clr_state", 64'(state),   64'd0);
    chk("prio_clr_cyc",   64'(cyc_cnt), 64'd0);

    // statistics: 4 branches (3 taken), 2 jumps while enabled
    cmd_run = 1; tick("stat_run");
    for (int i = 0; i < 6; i++) begin
      is_branch = (i < 4);
      branched  = (i < 3);
      is_jump   = (i >= 4);
      tick("stat_flags");
    end
    idle_inputs();
    cmd_stop = 1; tick("stat_stop");
    is_branch = 1; branched = 1; is_jump = 1;
    for (int i = 0; i < 3; i++) tick("stat_disabled");
    idle_inputs();
    chk("stat_br",  64'(br_cnt),  64'd4);
    chk("stat_tkn", 64'(tkn_cnt), 64'd3);
    chk("stat_jmp", 64'(jmp_cnt), 64'd2);

    // saturation with the 4-bit instance
    cmd_clr = 1; tick("sat_clr");
    cmd_run = 1; tick("sat_run");
    for (int i = 0; i < 20; i++) tick("sat_cycle");
    chk("sat_cyc4", 64'(cyc_cnt4), 64'd15);
    chk("sat_cyc",  64'(cyc_cnt),  64'd20);
    cmd_stop = 1; tick("sat_stop");

    // reset in the middle of a step
    step_num = 16'd10; cmd_step = 1; tick("rst_step");
    for (int i = 0; i < 3; i++) tick("rst_stepping");
    #2 rst_n = 0;
    #1;
    model_reset();
    chk("rst_mid_cpu_en", 64'(cpu_en), 64'd0);
    check_all("rst_mid");
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    check_all("rst_release");

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      cmd_clr   = ($urandom_range(0, 99) < 3);
      cmd_stop  = ($urandom_range(0, 99) < 8);
      cmd_step  = ($urandom_range(0, 99) < 12);
      cmd_run   = ($urandom_range(0, 99) < 15);
      step_num  = 16'($urandom_range(0, 6));
      halt      = ($urandom_range(0, 39) == 0) && !cmd_stop;
      is_jump   = 1'($urandom_range(0, 1));
      is_branch = 1'($urandom_range(0, 1));
      branched  = 1'($urandom_range(0, 1));
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/syn_run_ctrl.md
SYN_RUN_CTRL -- requirements
Module: syn_run_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of every statistics counter.
REQ-002 SHALL have parameter STEP_W, default 16, width of the step-count operand.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port cmd_run, input, 1, one-cycle pulse requesting free run.
REQ-006 SHALL have port cmd_step, input, 1, one-cycle pulse requesting step_num cycles.
REQ-007 SHALL have port cmd_stop, input, 1, one-cycle pulse requesting pause.
REQ-008 SHALL have port cmd_clr, input, 1, one-cycle pulse clearing counters and returning to IDLE.
REQ-009 SHALL have port step_num, input, STEP_W, cycle count, sampled only with cmd_step.
REQ-010 SHALL have port halt, input, 1, CPU syscall-halt flag.
REQ-011 SHALL have ports is_jump, is_branch and branched, input, 1 each, CPU per-cycle control-flow flags.
REQ-012 SHALL have port cpu_en, output, 1, the pipeline enable driven to the CPU en input.
REQ-013 SHALL have port state, output, 2, current FSM state code.
REQ-014 SHALL have ports cyc_cnt, jmp_cnt, br_cnt and tkn_cnt, output, CNT_W each, counting enabled cycles, jumps, branches and taken branches.

Function
REQ-015 SHALL implement the states IDLE=0, RUN=1, STEP=2 and HALTED=3.
REQ-016 SHALL drive cpu_en combinationally as (state==RUN or state==STEP) and !halt.
REQ-017 SHALL resolve simultaneous commands with priority cmd_clr > cmd_stop > cmd_step > cmd_run; lower-priority commands in the same cycle are dropped.
REQ-018 SHALL transition IDLE→RUN on cmd_run, and IDLE→STEP on cmd_step, loading remaining=step_num, with 0 treated as 1.
REQ-019 SHALL transition RUN→IDLE on cmd_stop and ignore cmd_step and cmd_run while in RUN.
REQ-020 SHALL decrement remaining by 1 in STEP on each cycle with cpu_en=1, and transition STEP→IDLE on the edge where remaining goes from 1 to 0; cmd_stop in STEP goes to IDLE and discards remaining.
REQ-021 SHALL transition any non-IDLE state to HALTED when halt=1 is sampled in RUN or STEP, with no decrement in that cycle.
REQ-022 SHALL leave HALTED only on cmd_clr; cmd_run, cmd_step and cmd_stop are ignored in HALTED.
REQ-023 SHALL, on cmd_clr in any state, go to IDLE, zero all counters and zero remaining on the next edge.
REQ-024 SHALL increment cyc_cnt once per cycle with cpu_en=1.
REQ-025 SHALL increment jmp_cnt, br_cnt and tkn_cnt in cycles with cpu_en=1 when is_jump, is_branch and (is_branch and branched) are 1, respectively.
REQ-026 SHALL make every counter saturate at 2^CNT_W-1 and never wrap.
REQ-027 SHALL register counter outputs, so that a value reflects increments up to the previous edge.
REQ-028 SHALL make the first cpu_en=1 cycle the cycle after the accepting command edge (one-cycle start latency).

Reset
REQ-029 SHALL, with rst_n=0, immediately force state=IDLE, remaining=0, all counters=0 and cpu_en=0, independent of clk.
REQ-030 SHALL treat rst_n deassertion in the middle of a run or step as a fresh start in IDLE; no command is remembered.

Structure
REQ-031 SHALL place the state codes (IDLE/RUN/STEP/HALTED) as named constants in the shared core header alongside the existing MUX and op defines.
REQ-032 SHALL instantiate one sub-module, syn_sat_counter (parameter W; inputs clk, rst_n, clr, inc; output cnt), four times.
REQ-033 SHALL contain no other hierarchy; the FSM and remaining counter are local to syn_run_ctrl.

Verification
REQ-034 SHALL test step: from IDLE, cmd_step with step_num=5 → cpu_en high for exactly 5 cycles, then state=IDLE and cyc_cnt=5.
REQ-035 SHALL test step of zero: cmd_step with step_num=0 → exactly 1 enabled cycle and cyc_cnt=1.
REQ-036 SHALL test halt: cmd_run, then halt=1 at enabled cycle 7 → cpu_en=0 in that same cycle, state=HALTED next edge, cyc_cnt=6; cmd_run is then ignored and cmd_clr returns to IDLE with all counters 0.
REQ-037 SHALL test priority: cmd_run and cmd_stop in the same cycle from RUN → IDLE; cmd_clr and cmd_step together → IDLE and counters cleared.
REQ-038 SHALL test statistics: in RUN, drive is_branch=1 for 4 cycles with branched=1 on 3 of them, and is_jump=1 for 2 cycles → br_cnt=4, tkn_cnt=3, jmp_cnt=2; the same flags with cpu_en=0 do not count.
REQ-039 SHALL test saturation and reset: with CNT_W=4, run 20 cycles → cyc_cnt=15; asserting rst_n=0 mid-STEP gives immediate IDLE, cpu_en=0 and counters 0.
